txd_man_gen: RTL and testbench
==============================

# txd_man_gen

Manchester line transmitter: the transmit end of the 1 MHz / 100 kHz Manchester link whose receive side performs rate lock and pulse-error detection. Accepts a parallel word on a start strobe and serialises it as a lock preamble, Manchester data MSB first, and a stop interval. The bit rate is selectable per frame. Drives the board TXD pin from the 20 MHz system clock.

## Interface
Parameters:
- DATA_W, 16, payload bits per frame
- NUM_PRE, 4, preamble bits (all '0'); minimum 3, so the receiver sees three rising edges
- HALF_1M, 8'd10, clk_20M cycles per half-bit at 1 Mbit/s
- HALF_100K, 8'd100, clk_20M cycles per half-bit at 100 kbit/s
- NUM_STOP, 2, stop-interval length in bit times (line held high)

Ports:
- clk_20M  in  1  system clock, 20 MHz
- clr  in  1  reset; one clock, asynchronous, active-high
- tx_start  in  1  frame request, sampled each rising clock edge
- tx_rate  in  1  1 = 1 Mbit/s, 0 = 100 kbit/s; sampled with an accepted tx_start
- tx_data  in  DATA_W  payload; sampled with an accepted tx_start
- txd  out  1  registered Manchester line; idle high
- tx_busy  out  1  high from the cycle after acceptance until the frame ends
- tx_done  out  1  one-cycle pulse at frame end

## Operation
- Encoding: bit '0' = low half, then high half (rising edge mid-bit). Bit '1' = high half, then low half.
- tx_start is accepted only when tx_busy = 0. On acceptance, latch tx_data into a shift register and latch tx_rate into half_len (HALF_1M or HALF_100K). Ignore tx_start at all other times.
- State machine: IDLE -> PRE -> DATA -> STOP -> IDLE.
  - IDLE: txd = 1.
  - PRE: NUM_PRE '0' bits.
  - DATA: DATA_W bits, MSB first; the shift register shifts left at each bit boundary.
  - STOP: txd = 1 for NUM_STOP*2*half_len cycles.
- Counters:
  - half_cnt: 8 bits; runs 0 .. half_len-1. A phase flag toggles at terminal count.
  - bit_cnt: 5 bits; counts bits within PRE and DATA, and half-bits within STOP. Resets at each state change.
- On STOP terminal count: go to IDLE. In that same cycle, tx_busy -> 0 and tx_done = 1.
- A tx_start present in the tx_done cycle is accepted, so frames can run back to back with exactly one idle-high cycle between them.
- tx_rate and tx_data changes mid-frame have no effect.
- clr asserted at any time, including mid-frame: txd = 1, tx_busy = 0, tx_done = 0, state IDLE, all counters 0. The outputs take these values asynchronously. The frame is abandoned with no done pulse.

## Timing
- Reset values: txd = 1, tx_busy = 0, tx_done = 0.
- tx_start accepted at edge N:
  - at N+1: tx_busy = 1 and txd = 0 (first half of preamble bit 0).
- Every half-bit is exactly half_len cycles: 10 at 1 Mbit/s, 100 at 100 kbit/s. There are no extra cycles at bit or state boundaries.
- Frame length from edge N+1 to the tx_done edge, exclusive: (NUM_PRE + DATA_W + NUM_STOP) * 2 * half_len cycles.
  - With the defaults: 440 cycles at 1 Mbit/s, 4400 cycles at 100 kbit/s.
- Preamble rising edges are spaced exactly 2*half_len cycles apart: 20 cycles (1 MHz) or 200 cycles (100 kHz).
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package:
  - state encoding (IDLE/PRE/DATA/STOP, 2 bits)
  - HALF_1M, HALF_100K
  - counter widths
  - the rate-select constant
  The receiver's lock window constants belong in the same package so both ends stay consistent.
- One natural sub-module, man_half_timer: loads half_len, counts, and emits a terminal-count pulse and the phase flag. The FSM, shift register, and output register stay in the top level.

## Test plan
- 1 Mbit/s, tx_data = 16'hA5C3 -> txd low 10 / high 10 ×4, then the Manchester pattern of 1010 0101 1100 0011, then 40 cycles high. tx_done 440 cycles after tx_busy rises.
- 100 kbit/s, tx_data = 16'h0001 -> every half-bit is 100 cycles, the last data bit is high 100 / low 100, and tx_done comes 4400 cycles after tx_busy rises.
- tx_start pulsed 50 cycles into a frame with tx_data = 16'hFFFF -> ignored: the frame in progress completes unchanged and no second frame follows.
- tx_start held high through tx_done -> second frame: txd low in the cycle after tx_done, with exactly one idle-high cycle between the frames.
- clr asserted 123 cycles into a 1 Mbit/s frame -> txd = 1 and tx_busy = 0 immediately, no tx_done. A new start after release gives a clean full frame.
- Loopback of txd into the 1M/100k lock receiver at 1 Mbit/s -> lock_stat = 1 before the preamble ends. At 100 kbit/s -> lock_stat = 0 and pulse_err = 0 after the preamble.

Source files
------------

// File: rtl/txd_man_gen_pkg.sv
// Shared constants for the 1 MHz / 100 kHz Manchester link (transmit and receive ends).
package txd_man_gen_pkg;

    // Counter widths
    localparam int HALF_W = 8;   // half-bit cycle counter
    localparam int BIT_W  = 5;   // bit / half-bit counter within a state

    // Half-bit lengths in 20 MHz cycles
    localparam logic [HALF_W-1:0] HALF_1M   = 8'd10;
    localparam logic [HALF_W-1:0] HALF_100K = 8'd100;

    // tx_rate value selecting the fast rate
    localparam logic RATE_1M = 1'b1;

    // Transmit FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;

    // Receiver lock window: rising-edge spacing accepted as 1 MHz lock,
    // and the number of consecutive in-window edges needed to lock.
    // The preamble spaces its rising edges 2*HALF_1M cycles apart.
    localparam logic [HALF_W-1:0] LOCK_SPACING_MIN = 8'd18;
    localparam logic [HALF_W-1:0] LOCK_SPACING_MAX = 8'd22;
    localparam int                LOCK_EDGES       = 3;

    // Pick the half-bit length for a requested rate
    function automatic logic [HALF_W-1:0] half_sel(input logic rate,
                                                   input logic [HALF_W-1:0] h_fast,
                                                   input logic [HALF_W-1:0] h_slow);
        return (rate == RATE_1M) ? h_fast : h_slow;
    endfunction

endpackage

// File: rtl/txd_man_gen_half_timer.sv
// Half-bit timer: counts 0..half_len-1, pulses tc on the last cycle of each
// half-bit and toggles the phase flag (0 = first half, 1 = second half).
module man_half_timer
    import txd_man_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic [HALF_W-1:0] len_in,
    output logic              tc,
    output logic              phase
);

    logic [HALF_W-1:0] half_len;
    logic [HALF_W-1:0] half_cnt;

    assign tc = run && (half_cnt == (half_len - HALF_W'(1)));

    // Load length on frame start, count while running, hold at zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_len <= '0;
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (load) begin
            half_len <= len_in;
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (!run) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (tc) begin
            half_cnt <= '0;
            phase    <= ~phase;
        end else begin
            half_cnt <= half_cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/txd_man_gen.sv
// Manchester line transmitter: preamble of '0' bits, payload MSB first, then a
// high stop interval. '0' = low then high, '1' = high then low.
module txd_man_gen #(
    parameter int          DATA_W    = 16,
    parameter int          NUM_PRE   = 4,
    parameter logic [7:0]  HALF_1M   = txd_man_gen_pkg::HALF_1M,
    parameter logic [7:0]  HALF_100K = txd_man_gen_pkg::HALF_100K,
    parameter int          NUM_STOP  = 2
) (
    input  logic              clk_20M,
    input  logic              clr,
    input  logic              tx_start,
    input  logic              tx_rate,
    input  logic [DATA_W-1:0] tx_data,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done
);

    import txd_man_gen_pkg::*;

    localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(NUM_PRE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(2 * NUM_STOP - 1);

    logic [1:0]        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              accept;
    logic              tc;
    logic              phase;

    // A request is taken only while no frame is running, including the done cycle
    assign accept = tx_start && !tx_busy;

    man_half_timer u_timer (
        .clk    (clk_20M),
        .rst    (clr),
        .load   (accept),
        .run    (tx_busy),
        .len_in (half_sel(tx_rate, HALF_1M, HALF_100K)),
        .tc     (tc),
        .phase  (phase)
    );

    // Frame sequencing; txd is loaded with the level of the half-bit that starts next
    always_ff @(posedge clk_20M or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (accept) begin
                state   <= ST_PRE;
                bit_cnt <= '0;
                shreg   <= tx_data;
                txd     <= 1'b0;
                tx_busy <= 1'b1;
            end else if (tc) begin
                case (state)
                    ST_PRE: begin
                        if (!phase) begin
                            txd <= 1'b1;
                        end else if (bit_cnt == PRE_LAST) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            txd     <= shreg[DATA_W-1];
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            txd     <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (!phase) begin
                            txd <= ~shreg[DATA_W-1];
                        end else if (bit_cnt == DATA_LAST) begin
                            state   <= ST_STOP;
                            bit_cnt <= '0;
                            txd     <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            txd     <= shreg[DATA_W-2];
                        end
                    end
                    ST_STOP: begin
                        // stop interval is counted in half-bits
                        if (bit_cnt == STOP_LAST) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            txd     <= 1'b1;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_txd_man_gen.sv
// Self-checking bench for txd_man_gen: expected line waveform is built from the
// Manchester rules (bit list -> half-bit levels -> cycles) and compared per frame.
module tb_txd_man_gen;

    localparam int DATA_W   = 16;
    localparam int NUM_PRE  = 4;
    localparam int NUM_STOP = 2;

    logic              clk_20M = 1'b0;
    logic              clr;
    logic              tx_start;
    logic              tx_rate;
    logic [DATA_W-1:0] tx_data;
    logic              txd;
    logic              tx_busy;
    logic              tx_done;

    int tests = 0;
    int fails = 0;
    logic exp_w[$];

    txd_man_gen #(
        .DATA_W    (DATA_W),
        .NUM_PRE   (NUM_PRE),
        .HALF_1M   (8'd10),
        .HALF_100K (8'd100),
        .NUM_STOP  (NUM_STOP)
    ) dut (
        .clk_20M  (clk_20M),
        .clr      (clr),
        .tx_start (tx_start),
        .tx_rate  (tx_rate),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #25 clk_20M = ~clk_20M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_20M);
        #1;
    endtask

    // Expected txd from the cycle after acceptance up to (not including) the done cycle
    task automatic build_model(input logic rate, input logic [DATA_W-1:0] d);
        int   hl;
        logic halves[$];
        hl = rate ? 10 : 100;
        exp_w.delete();
        for (int i = 0; i < NUM_PRE; i++) begin
            halves.push_back(1'b0);
            halves.push_back(1'b1);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            halves.push_back(d[i]);
            halves.push_back(~d[i]);
        end
        for (int i = 0; i < 2 * NUM_STOP; i++) halves.push_back(1'b1);
        foreach (halves[k]) repeat (hl) exp_w.push_back(halves[k]);
    endtask

    // One frame; stray_at >= 0 pulses tx_start with all-ones data mid-frame,
    // hold keeps tx_start high through tx_done for a back-to-back follow-on.
    task automatic run_frame(input string tag, input logic rate, input logic [DATA_W-1:0] d,
                             input int stray_at, input bit hold);
        int n;
        int first_bad;
        build_model(rate, d);
        tx_start = 1'b1;
        tx_rate  = rate;
        tx_data  = d;
        tick();
        if (!hold) tx_start = 1'b0;
        check({tag, " busy_rise"}, 32'(tx_busy), 32'd1);
        n = 0;
        first_bad = -1;
        while (tx_busy === 1'b1 && n < 6000) begin
            if (first_bad < 0 && (n >= exp_w.size() || txd !== exp_w[n] || tx_done !== 1'b0))
                first_bad = n;
            if (n == stray_at) begin
                tx_start = 1'b1;
                tx_data  = '1;
            end else begin
                if (!hold) tx_start = 1'b0;
                tx_data = DATA_W'($urandom);
            end
            tx_rate = 1'($urandom_range(0, 1));
            n++;
            tick();
        end
        check({tag, " frame_len"}, 32'(n), 32'(exp_w.size()));
        check({tag, " wave_first_bad"}, 32'(first_bad), 32'hffff_ffff);
        check({tag, " done_pulse"}, 32'(tx_done), 32'd1);
        check({tag, " done_txd"}, 32'(txd), 32'd1);
        if (!hold) begin
            tx_start = 1'b0;
            tick();
            check({tag, " done_clears"}, 32'(tx_done), 32'd0);
            check({tag, " idle_after"}, 32'(tx_busy), 32'd0);
        end
    endtask

    initial begin
        int seen_done;
        clr      = 1'b1;
        tx_start = 1'b0;
        tx_rate  = 1'b0;
        tx_data  = '0;
        tick();
        tick();
        check("rst txd", 32'(txd), 32'd1);
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst done", 32'(tx_done), 32'd0);
        clr = 1'b0;
        tick();
        check("idle txd", 32'(txd), 32'd1);

        run_frame("a5c3_1m", 1'b1, 16'hA5C3, -1, 1'b0);
        run_frame("0001_100k", 1'b0, 16'h0001, -1, 1'b0);
        run_frame("stray_start", 1'b1, DATA_W'($urandom), 50, 1'b0);
        run_frame("hold_a", 1'b1, DATA_W'($urandom), -1, 1'b1);
        run_frame("hold_b", 1'b0, DATA_W'($urandom), -1, 1'b0);

        // abort a frame with clr 123 cycles in
        tx_start = 1'b1;
        tx_rate  = 1'b1;
        tx_data  = DATA_W'($urandom);
        tick();
        tx_start = 1'b0;
        repeat (123) tick();
        check("pre_clr busy", 32'(tx_busy), 32'd1);
        clr = 1'b1;
        #1;
        check("clr txd", 32'(txd), 32'd1);
        check("clr busy", 32'(tx_busy), 32'd0);
        check("clr done", 32'(tx_done), 32'd0);
        tick();
        clr = 1'b0;
        seen_done = 0;
        repeat (500) begin
            tick();
            if (tx_done !== 1'b0 || tx_busy !== 1'b0 || txd !== 1'b1) seen_done++;
        end
        check("clr no_resume", 32'(seen_done), 32'd0);
        run_frame("after_clr", 1'b1, DATA_W'($urandom), -1, 1'b0);

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), DATA_W'($urandom), -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
